upc_loop_monitor: RTL and testbench

UPC_LOOP_MONITOR -- requirements
Module: upc_loop_monitor

---
 rtl/upc_loop_monitor.sv | 171 +++++++++++++++++
 tb/tb_upc_loop_monitor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/upc_loop_monitor.sv
// Performance monitor for an HLS-style module handshake and one pipelined loop FSM.
// Counts module starts/dones/busy cycles and loop iterations, invocations, stalls and trip counts.
module upc_loop_monitor #(
  parameter int STATE_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  output logic [1:0]         mod_state,
  output logic [CNT_W-1:0]   mod_start_cnt,
  output logic [CNT_W-1:0]   mod_done_cnt,
  output logic [CNT_W-1:0]   mod_busy_cycles,
  output logic               loop_active,
  output logic [CNT_W-1:0]   iter_start_cnt,
  output logic [CNT_W-1:0]   iter_end_cnt,
  output logic [CNT_W-1:0]   loop_invoc_cnt,
  output logic [CNT_W-1:0]   loop_stall_cycles,
  output logic [CNT_W-1:0]   last_trip_cnt,
  output logic [CNT_W-1:0]   in_flight,
  output logic               finished
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_DONE_WAIT = 2'd2
  } mod_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  mod_state_t       r_mod_state;
  logic [CNT_W-1:0] r_mod_start_cnt;
  logic [CNT_W-1:0] r_mod_done_cnt;
  logic [CNT_W-1:0] r_mod_busy_cycles;
  logic             r_loop_active;
  logic [CNT_W-1:0] r_iter_start_cnt;
  logic [CNT_W-1:0] r_iter_end_cnt;
  logic [CNT_W-1:0] r_loop_invoc_cnt;
  logic [CNT_W-1:0] r_loop_stall_cycles;
  logic [CNT_W-1:0] r_last_trip_cnt;
  logic [CNT_W-1:0] r_in_flight;
  logic [CNT_W-1:0] r_trip_cnt;
  logic             r_finished;

  logic             w_s;
  logic             w_e;
  logic             w_q;
  logic             w_inv_start;
  logic             w_stall;
  logic             w_frozen;
  logic [CNT_W-1:0] w_trip_with_e;
  logic             w_unused;

  assign w_s = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
  assign w_e = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
  assign w_q = quit_at_end ? (loop_done & loop_continue)
                           : ((cur_state == quit_state) & quit_enable & ~quit_block);

  // A loop_start coinciding with the quit of a running invocation begins a new one.
  assign w_inv_start   = loop_start & (~r_loop_active | w_q);
  assign w_stall       = r_loop_active & (cur_state == iter_start_state) & iter_start_block;
  assign w_trip_with_e = w_e ? sat_inc(r_trip_cnt) : r_trip_cnt;
  // The edge that first sees finish is already frozen.
  assign w_frozen      = finish | r_finished;
  assign w_unused      = loop_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_finished <= 1'b0;
    end else if (finish) begin
      r_finished <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mod_state       <= ST_IDLE;
      r_mod_start_cnt   <= '0;
      r_mod_done_cnt    <= '0;
      r_mod_busy_cycles <= '0;
    end else if (!w_frozen) begin
      case (r_mod_state)
        ST_IDLE: begin
          if (ap_start) r_mod_state <= ST_RUN;
        end
        ST_RUN: begin
          if (ap_done && ap_continue) r_mod_state <= ap_start ? ST_RUN : ST_IDLE;
          else if (ap_done)           r_mod_state <= ST_DONE_WAIT;
        end
        ST_DONE_WAIT: begin
          if (ap_continue) r_mod_state <= ST_IDLE;
        end
        default: r_mod_state <= ST_IDLE;
      endcase
      if (ap_start && ap_ready)    r_mod_start_cnt   <= sat_inc(r_mod_start_cnt);
      if (ap_done && ap_continue)  r_mod_done_cnt    <= sat_inc(r_mod_done_cnt);
      if (r_mod_state != ST_IDLE)  r_mod_busy_cycles <= sat_inc(r_mod_busy_cycles);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_loop_active       <= 1'b0;
      r_iter_start_cnt    <= '0;
      r_iter_end_cnt      <= '0;
      r_loop_invoc_cnt    <= '0;
      r_loop_stall_cycles <= '0;
      r_last_trip_cnt     <= '0;
      r_in_flight         <= '0;
      r_trip_cnt          <= '0;
    end else if (!w_frozen) begin
      if (w_inv_start) begin
        r_loop_active    <= 1'b1;
        r_loop_invoc_cnt <= sat_inc(r_loop_invoc_cnt);
      end else if (w_q) begin
        r_loop_active <= 1'b0;
      end

      if (w_inv_start) r_trip_cnt <= '0;
      else if (w_e)    r_trip_cnt <= sat_inc(r_trip_cnt);

      // The quitting cycle's own E belongs to the invocation that is ending.
      if (w_q) r_last_trip_cnt <= w_trip_with_e;

      if (w_s)     r_iter_start_cnt    <= sat_inc(r_iter_start_cnt);
      if (w_e)     r_iter_end_cnt      <= sat_inc(r_iter_end_cnt);
      if (w_stall) r_loop_stall_cycles <= sat_inc(r_loop_stall_cycles);

      if (w_s && !w_e)                       r_in_flight <= sat_inc(r_in_flight);
      else if (w_e && !w_s && |r_in_flight)  r_in_flight <= r_in_flight - CNT_ONE;
    end
  end

  assign mod_state         = r_mod_state;
  assign mod_start_cnt     = r_mod_start_cnt;
  assign mod_done_cnt      = r_mod_done_cnt;
  assign mod_busy_cycles   = r_mod_busy_cycles;
  assign loop_active       = r_loop_active;
  assign iter_start_cnt    = r_iter_start_cnt;
  assign iter_end_cnt      = r_iter_end_cnt;
  assign loop_invoc_cnt    = r_loop_invoc_cnt;
  assign loop_stall_cycles = r_loop_stall_cycles;
  assign last_trip_cnt     = r_last_trip_cnt;
  assign in_flight         = r_in_flight;
  assign finished          = r_finished;

endmodule

// File: tb/tb_upc_loop_monitor.sv
// Directed bench for upc_loop_monitor: a 32-bit instance plus a 4-bit instance for saturation.
module tb_upc_loop_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       finish = 1'b0;
  logic       ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b0;
  logic [2:0] cur_state = 3'd0, iter_start_state = 3'd0, iter_end_state = 3'd0, quit_state = 3'd0;
  logic       iter_start_block = 1'b0, iter_end_block = 1'b0, quit_block = 1'b0;
  logic       iter_start_enable = 1'b0, iter_end_enable = 1'b0, quit_enable = 1'b0;
  logic       loop_start = 1'b0, loop_ready = 1'b0, loop_done = 1'b0, loop_continue = 1'b0;
  logic       quit_at_end = 1'b0;

  logic [1:0]  mod_state;
  logic [31:0] mod_start_cnt, mod_done_cnt, mod_busy_cycles;
  logic        loop_active;
  logic [31:0] iter_start_cnt, iter_end_cnt, loop_invoc_cnt, loop_stall_cycles, last_trip_cnt;
  logic [31:0] in_flight;
  logic        finished;

  logic [1:0] s_mod_state;
  logic [3:0] s_mod_start_cnt, s_mod_done_cnt, s_mod_busy_cycles;
  logic       s_loop_active;
  logic [3:0] s_iter_start_cnt, s_iter_end_cnt, s_loop_invoc_cnt, s_loop_stall_cycles;
  logic [3:0] s_last_trip_cnt, s_in_flight;
  logic       s_finished;

  int n_total = 0;
  int n_pass  = 0;
  int peak;
  int exp_if[9] = '{1, 2, 3, 3, 3, 3, 2, 1, 0};

  always #5 clock = ~clock;

  upc_loop_monitor #(.STATE_W(3), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .mod_state(mod_state), .mod_start_cnt(mod_start_cnt), .mod_done_cnt(mod_done_cnt),
    .mod_busy_cycles(mod_busy_cycles), .loop_active(loop_active),
    .iter_start_cnt(iter_start_cnt), .iter_end_cnt(iter_end_cnt),
    .loop_invoc_cnt(loop_invoc_cnt), .loop_stall_cycles(loop_stall_cycles),
    .last_trip_cnt(last_trip_cnt), .in_flight(in_flight), .finished(finished)
  );

  upc_loop_monitor #(.STATE_W(3), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .mod_state(s_mod_state), .mod_start_cnt(s_mod_start_cnt), .mod_done_cnt(s_mod_done_cnt),
    .mod_busy_cycles(s_mod_busy_cycles), .loop_active(s_loop_active),
    .iter_start_cnt(s_iter_start_cnt), .iter_end_cnt(s_iter_end_cnt),
    .loop_invoc_cnt(s_loop_invoc_cnt), .loop_stall_cycles(s_loop_stall_cycles),
    .last_trip_cnt(s_last_trip_cnt), .in_flight(s_in_flight), .finished(s_finished)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("ok   %s = %0d", tag, obs);
    end else begin
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    finish = 1'b0;
    ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b0;
    iter_start_block = 1'b0; iter_end_block = 1'b0; quit_block = 1'b0;
    iter_start_enable = 1'b0; iter_end_enable = 1'b0; quit_enable = 1'b0;
    loop_start = 1'b0; loop_done = 1'b0; loop_continue = 1'b0; quit_at_end = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    cur_state = 3'b010; iter_start_state = 3'b010;
    iter_end_state = 3'b010; quit_state = 3'b010;

    // Reset state, checked before any clock edge
    #1 reset = 1'b0;
    #2;
    chk("rst_mod_state", 32'(mod_state), 32'd0);
    chk("rst_iter_start", iter_start_cnt, 32'd0);
    chk("rst_in_flight", in_flight, 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // DONE_WAIT path
    ap_start = 1'b1; ap_ready = 1'b1;
    tick();
    chk("dw_state_c0", 32'(mod_state), 32'd1);
    chk("dw_start_cnt", mod_start_cnt, 32'd1);
    ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b1; ap_continue = 1'b0;
    tick();
    chk("dw_state_c1", 32'(mod_state), 32'd2);
    chk("dw_done_c1", mod_done_cnt, 32'd0);
    tick();
    chk("dw_state_c2", 32'(mod_state), 32'd2);
    chk("dw_done_c2", mod_done_cnt, 32'd0);
    ap_continue = 1'b1;
    tick();
    chk("dw_state_c3", 32'(mod_state), 32'd0);
    chk("dw_done_c3", mod_done_cnt, 32'd1);
    chk("dw_busy", mod_busy_cycles, 32'd3);

    // Module handshake: start, three RUN cycles, done with continue
    do_reset();
    ap_start = 1'b1; ap_ready = 1'b1;
    tick();
    ap_start = 1'b0; ap_ready = 1'b0;
    repeat (3) tick();
    ap_done = 1'b1; ap_continue = 1'b1;
    tick();
    ap_done = 1'b0; ap_continue = 1'b0;
    chk("hs_start_cnt", mod_start_cnt, 32'd1);
    chk("hs_done_cnt", mod_done_cnt, 32'd1);
    chk("hs_busy", mod_busy_cycles, 32'd4);
    chk("hs_state", 32'(mod_state), 32'd0);
    // Back-to-back: done, continue and a new start together keep RUN
    ap_start = 1'b1; ap_ready = 1'b1;
    tick();
    ap_done = 1'b1; ap_continue = 1'b1;
    tick();
    clear_inputs();
    chk("b2b_state", 32'(mod_state), 32'd1);
    chk("b2b_start_cnt", mod_start_cnt, 32'd3);
    chk("b2b_done_cnt", mod_done_cnt, 32'd2);

    // Pipelined loop: 6 iterations, II=1, depth 3, quit on the last E
    do_reset();
    peak = 0;
    for (int c = 0; c < 9; c++) begin
      loop_start        = (c == 0);
      iter_start_enable = (c <= 5);
      iter_end_enable   = (c >= 3);
      quit_enable       = (c == 8);
      tick();
      if (c == 0) chk("pl_active_c0", 32'(loop_active), 32'd1);
      chk($sformatf("pl_in_flight_c%0d", c), in_flight, 32'(exp_if[c]));
      if (int'(in_flight) > peak) peak = int'(in_flight);
    end
    clear_inputs();
    chk("pl_peak", 32'(peak), 32'd3);
    chk("pl_iter_start", iter_start_cnt, 32'd6);
    chk("pl_iter_end", iter_end_cnt, 32'd6);
    chk("pl_last_trip", last_trip_cnt, 32'd6);
    chk("pl_invoc", loop_invoc_cnt, 32'd1);
    chk("pl_active_end", 32'(loop_active), 32'd0);

    // Stall: 5 blocked cycles, quit via loop_done&loop_continue
    do_reset();
    quit_at_end = 1'b1;
    loop_start = 1'b1; iter_start_enable = 1'b1;
    tick();
    loop_start = 1'b0;
    iter_end_enable = 1'b1; iter_start_block = 1'b1; iter_end_block = 1'b1;
    repeat (5) tick();
    chk("st_stall_mid", loop_stall_cycles, 32'd5);
    chk("st_start_mid", iter_start_cnt, 32'd1);
    chk("st_end_mid", iter_end_cnt, 32'd0);
    iter_start_enable = 1'b0; iter_start_block = 1'b0; iter_end_block = 1'b0;
    loop_done = 1'b1; loop_continue = 1'b1;
    tick();
    clear_inputs();
    chk("st_stall", loop_stall_cycles, 32'd5);
    chk("st_iter_end", iter_end_cnt, 32'd1);
    chk("st_last_trip", last_trip_cnt, 32'd1);
    chk("st_in_flight", in_flight, 32'd0);
    chk("st_active", 32'(loop_active), 32'd0);

    // Finish freeze mid-loop
    do_reset();
    loop_start = 1'b1; iter_start_enable = 1'b1;
    tick();
    loop_start = 1'b0; iter_start_enable = 1'b0;
    finish = 1'b1; ap_start = 1'b1; ap_ready = 1'b1;
    tick();
    chk("fin_flag", 32'(finished), 32'd1);
    finish = 1'b0; iter_start_enable = 1'b1;
    repeat (10) tick();
    clear_inputs();
    chk("fin_flag_sticky", 32'(finished), 32'd1);
    chk("fin_iter_start", iter_start_cnt, 32'd1);
    chk("fin_in_flight", in_flight, 32'd1);
    chk("fin_invoc", loop_invoc_cnt, 32'd1);
    chk("fin_mod_start", mod_start_cnt, 32'd0);
    chk("fin_mod_state", 32'(mod_state), 32'd0);

    // Reset mid-loop with two iterations in flight clears without a clock edge
    do_reset();
    chk("rst_clears_finished", 32'(finished), 32'd0);
    loop_start = 1'b1; iter_start_enable = 1'b1;
    tick();
    loop_start = 1'b0;
    tick();
    chk("rml_in_flight_pre", in_flight, 32'd2);
    reset = 1'b0;
    #1;
    chk("rml_in_flight", in_flight, 32'd0);
    chk("rml_iter_start", iter_start_cnt, 32'd0);
    chk("rml_active", 32'(loop_active), 32'd0);
    chk("rml_invoc", loop_invoc_cnt, 32'd0);
    clear_inputs();
    @(negedge clock);
    reset = 1'b1;

    // Saturation: 20 S events, 4-bit counters stop at 15
    iter_start_enable = 1'b1;
    repeat (20) tick();
    clear_inputs();
    chk("sat_wide_start", iter_start_cnt, 32'd20);
    chk("sat_narrow_start", 32'(s_iter_start_cnt), 32'd15);
    chk("sat_narrow_in_flight", 32'(s_in_flight), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
